// File: rtl/insn_coverage_pkg.sv
// insn_coverage_pkg: shared types, decoder class-vector lengths and one-hot helper
//   state_e       collector FSM states
//   LEN_*         class-vector widths of the attached isa_coverage decoders
//   onehot0(vec)  true when vec has at most one bit set
package insn_coverage_pkg;

    typedef enum logic {RUN, CLEAR} state_e;

    localparam int LEN_RV32I  = 40;
    localparam int LEN_RV32IC = 66;
    localparam int LEN_RV64I  = 52;
    localparam int LEN_RV64IC = 82;

    // Widest class vector the helper accepts; callers zero-extend into it.
    localparam int ONEHOT_W = 128;

    // Clearing the lowest set bit leaves zero iff at most one bit was set,
    // equivalent to vec == (vec & -vec).
    function automatic logic onehot0(input logic [ONEHOT_W-1:0] vec);
        return (vec & (vec - 1'b1)) == '0;
    endfunction

endpackage

// File: rtl/insn_coverage_sat_counter.sv
// insn_coverage_sat_counter: CNT_W counter that saturates at all-ones
//   clock, resetn  clock and asynchronous active-low reset
//   inc_i          increment (ignored once saturated)
//   clr_i          synchronous clear, wins over inc_i
//   cnt_o          current count
module insn_coverage_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = clr_i ? '0 : (inc_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/insn_coverage_collector.sv
// insn_coverage_collector: accumulates ISA class coverage from a decoder one-hot vector
//   clock, resetn          clock and asynchronous active-low reset
//   in_valid/in_ready      class vector beat handshake, in_class one-hot or zero
//   clear_req/clear_busy   start / progress of the counter clear sweep
//   rd_req/rd_ready/rd_idx counter readout request, index N_CLASSES = unknown counter
//   rd_valid/rd_data       readout result, one cycle after acceptance
//   hit_map/all_covered    classes seen so far, and all of them seen
//   onehot_err             sticky flag for multi-hot beats
//   total_cnt              accepted beats, wrapping
module insn_coverage_collector
    import insn_coverage_pkg::*;
#(
    parameter int N_CLASSES = 40,
    parameter int CNT_W     = 16,
    parameter int IDX_W     = $clog2(N_CLASSES + 1)
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_CLASSES-1:0] in_class,
    input  logic                 clear_req,
    output logic                 clear_busy,
    input  logic                 rd_req,
    output logic                 rd_ready,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_valid,
    output logic [CNT_W-1:0]     rd_data,
    output logic [N_CLASSES-1:0] hit_map,
    output logic                 all_covered,
    output logic                 onehot_err,
    output logic [31:0]          total_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     sweep_q, sweep_d;
    logic [N_CLASSES-1:0] hit_q, hit_d;
    logic [31:0]          total_q, total_d;
    logic                 err_q, err_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0]     rd_data_q, rd_data_d;

    logic                 run, clr_first, beat, cls_zero, cls_one, rd_acc;
    logic [CNT_W-1:0]     rd_sel;
    logic [N_CLASSES:0]   inc, clr;
    logic [CNT_W-1:0]     cnt [N_CLASSES+1];

    always_comb begin
        run       = state_q == RUN;
        clr_first = !run && sweep_q == '0;
        beat      = in_valid && run;
        cls_zero  = in_class == '0;
        cls_one   = !cls_zero && onehot0(ONEHOT_W'(in_class));
        rd_acc    = rd_req && run;
        // Index N_CLASSES is the unknown counter; multi-hot beats touch no counter.
        inc       = {beat && cls_zero, (beat && cls_one) ? in_class : '0};
        rd_sel    = '0;
        for (int k = 0; k <= N_CLASSES; k++)
            if (rd_idx == IDX_W'(k)) rd_sel = cnt[k];
        state_d    = run ? (clear_req ? CLEAR : RUN) : (sweep_q == LAST_IDX ? RUN : CLEAR);
        sweep_d    = (run || sweep_q == LAST_IDX) ? '0 : sweep_q + 1'b1;
        hit_d      = clr_first ? '0 : hit_q | ((beat && cls_one) ? in_class : '0);
        total_d    = clr_first ? '0 : total_q + 32'(beat);
        err_d      = clr_first ? 1'b0 : err_q | (beat && !cls_zero && !cls_one);
        rd_valid_d = rd_acc;
        rd_data_d  = rd_acc ? rd_sel : rd_data_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= RUN;
            sweep_q    <= '0;
            hit_q      <= '0;
            total_q    <= '0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            hit_q      <= hit_d;
            total_q    <= total_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // One counter zeroed per CLEAR cycle, selected by the sweep index.
    for (genvar g = 0; g <= N_CLASSES; g++) begin : g_cnt
        assign clr[g] = !run && sweep_q == IDX_W'(g);
        insn_coverage_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clock  (clock),
            .resetn (resetn),
            .inc_i  (inc[g]),
            .clr_i  (clr[g]),
            .cnt_o  (cnt[g])
        );
    end

    assign in_ready    = run;
    assign rd_ready    = run;
    assign clear_busy  = !run;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign hit_map     = hit_q;
    assign all_covered = &hit_q;
    assign onehot_err  = err_q;
    assign total_cnt   = total_q;

endmodule

// File: tb/tb_insn_coverage_collector.sv
// tb_insn_coverage_collector: directed table-driven bench for insn_coverage_collector
module tb_insn_coverage_collector;

    localparam int N = 40;
    localparam int IW = 6;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          in_valid = 1'b0;
    logic [N-1:0]  in_class = '0;
    logic          clear_req = 1'b0;
    logic          rd_req = 1'b0;
    logic [IW-1:0] rd_idx = '0;

    logic          in_ready, clear_busy, rd_ready, rd_valid, all_covered, onehot_err;
    logic [15:0]   rd_data;
    logic [N-1:0]  hit_map;
    logic [31:0]   total_cnt;

    logic          in_ready_s, clear_busy_s, rd_ready_s, rd_valid_s, all_covered_s, onehot_err_s;
    logic [3:0]    rd_data_s;
    logic [N-1:0]  hit_map_s;
    logic [31:0]   total_cnt_s;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    insn_coverage_collector #(.N_CLASSES(N), .CNT_W(16)) dut (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .clear_req(clear_req), .clear_busy(clear_busy),
        .rd_req(rd_req), .rd_ready(rd_ready), .rd_idx(rd_idx), .rd_valid(rd_valid),
        .rd_data(rd_data), .hit_map(hit_map), .all_covered(all_covered),
        .onehot_err(onehot_err), .total_cnt(total_cnt)
    );

    insn_coverage_collector #(.N_CLASSES(N), .CNT_W(4)) dut_s (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_class(in_class), .clear_req(clear_req), .clear_busy(clear_busy_s),
        .rd_req(rd_req), .rd_ready(rd_ready_s), .rd_idx(rd_idx), .rd_valid(rd_valid_s),
        .rd_data(rd_data_s), .hit_map(hit_map_s), .all_covered(all_covered_s),
        .onehot_err(onehot_err_s), .total_cnt(total_cnt_s)
    );

    typedef struct {
        logic          iv;
        logic [N-1:0]  cls;
        logic          rr;
        logic [IW-1:0] ri;
        logic          erv;
        logic [15:0]   erd;
        logic [31:0]   etot;
        logic [N-1:0]  ehit;
        logic          eerr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic iv, logic [N-1:0] cls, logic rr, logic [IW-1:0] ri,
                                logic erv, logic [15:0] erd, logic [31:0] etot,
                                logic [N-1:0] ehit, logic eerr);
        vec_t v;
        v.iv = iv; v.cls = cls; v.rr = rr; v.ri = ri; v.erv = erv;
        v.erd = erd; v.etot = etot; v.ehit = ehit; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        in_valid = 1'b0;
        rd_req = 1'b0;
        clear_req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic beat(input logic [N-1:0] cls);
        in_valid = 1'b1;
        in_class = cls;
        @(negedge clock);
        in_valid = 1'b0;
        in_class = '0;
    endtask

    task automatic rd(input logic [IW-1:0] idx);
        rd_req = 1'b1;
        rd_idx = idx;
        @(negedge clock);
        rd_req = 1'b0;
    endtask

    initial begin
        int n;
        int nrdy;
        logic [N-1:0] one;
        one = 1;

        tbl.push_back(mk(1'b1, 40'h8,  1'b0, 6'd0,  1'b0, 16'd0, 32'd1,  40'h08, 1'b0));
        tbl.push_back(mk(1'b1, 40'h8,  1'b0, 6'd0,  1'b0, 16'd0, 32'd2,  40'h08, 1'b0));
        tbl.push_back(mk(1'b1, 40'h8,  1'b0, 6'd0,  1'b0, 16'd0, 32'd3,  40'h08, 1'b0));
        tbl.push_back(mk(1'b1, 40'h80, 1'b0, 6'd0,  1'b0, 16'd0, 32'd4,  40'h88, 1'b0));
        tbl.push_back(mk(1'b0, 40'h0,  1'b1, 6'd3,  1'b1, 16'd3, 32'd4,  40'h88, 1'b0));
        tbl.push_back(mk(1'b0, 40'h0,  1'b1, 6'd7,  1'b1, 16'd1, 32'd4,  40'h88, 1'b0));
        tbl.push_back(mk(1'b0, 40'h0,  1'b0, 6'd0,  1'b0, 16'd1, 32'd4,  40'h88, 1'b0));
        tbl.push_back(mk(1'b1, 40'h0,  1'b1, 6'd40, 1'b1, 16'd0, 32'd5,  40'h88, 1'b0));
        tbl.push_back(mk(1'b1, 40'h0,  1'b1, 6'd40, 1'b1, 16'd1, 32'd6,  40'h88, 1'b0));
        tbl.push_back(mk(1'b0, 40'h0,  1'b1, 6'd40, 1'b1, 16'd2, 32'd6,  40'h88, 1'b0));
        tbl.push_back(mk(1'b0, 40'h0,  1'b1, 6'd63, 1'b1, 16'd0, 32'd6,  40'h88, 1'b0));
        tbl.push_back(mk(1'b1, 40'h5,  1'b0, 6'd0,  1'b0, 16'd0, 32'd7,  40'h88, 1'b1));
        tbl.push_back(mk(1'b0, 40'h0,  1'b1, 6'd0,  1'b1, 16'd0, 32'd7,  40'h88, 1'b1));
        tbl.push_back(mk(1'b0, 40'h0,  1'b1, 6'd2,  1'b1, 16'd0, 32'd7,  40'h88, 1'b1));
        tbl.push_back(mk(1'b1, 40'h20, 1'b1, 6'd5,  1'b1, 16'd0, 32'd8,  40'ha8, 1'b1));
        tbl.push_back(mk(1'b1, 40'h20, 1'b1, 6'd5,  1'b1, 16'd1, 32'd9,  40'ha8, 1'b1));
        tbl.push_back(mk(1'b1, 40'h20, 1'b1, 6'd5,  1'b1, 16'd2, 32'd10, 40'ha8, 1'b1));
        tbl.push_back(mk(1'b0, 40'h0,  1'b1, 6'd5,  1'b1, 16'd3, 32'd10, 40'ha8, 1'b1));

        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        do_reset();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_rd_ready", 64'(rd_ready), 64'd1);
        chk("rst_clear_busy", 64'(clear_busy), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_hit_map", 64'(hit_map), 64'd0);
        chk("rst_total", 64'(total_cnt), 64'd0);
        chk("rst_err", 64'(onehot_err), 64'd0);

        foreach (tbl[i]) begin
            in_valid = tbl[i].iv;
            in_class = tbl[i].cls;
            rd_req = tbl[i].rr;
            rd_idx = tbl[i].ri;
            @(negedge clock);
            chk($sformatf("row%0d_rd_valid", i), 64'(rd_valid), 64'(tbl[i].erv));
            chk($sformatf("row%0d_rd_data", i), 64'(rd_data), 64'(tbl[i].erd));
            chk($sformatf("row%0d_total", i), 64'(total_cnt), 64'(tbl[i].etot));
            chk($sformatf("row%0d_hit_map", i), 64'(hit_map), 64'(tbl[i].ehit));
            chk($sformatf("row%0d_err", i), 64'(onehot_err), 64'(tbl[i].eerr));
        end
        in_valid = 1'b0;
        in_class = '0;
        rd_req = 1'b0;

        // Saturation: 20 hits on class 1; 4-bit instance must stop at 15.
        do_reset();
        for (int i = 0; i < 20; i++) beat(40'h2);
        rd(6'd1);
        chk("sat_wide", 64'(rd_data), 64'd20);
        chk("sat_narrow", 64'(rd_data_s), 64'd15);
        chk("sat_total_narrow", 64'(total_cnt_s), 64'd20);

        // Full coverage boundary.
        do_reset();
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) chk("cov_before_last", 64'(all_covered), 64'd0);
            beat(one << i);
        end
        chk("cov_all", 64'(all_covered), 64'd1);
        beat(40'h3);
        chk("cov_err", 64'(onehot_err), 64'd1);
        chk("cov_total", 64'(total_cnt), 64'd41);

        // Clear sweep with a second request mid-sweep.
        clear_req = 1'b1;
        @(negedge clock);
        clear_req = 1'b0;
        n = 0;
        nrdy = 0;
        while (clear_busy && n < 200) begin
            n++;
            if (in_ready == 1'b0 && rd_ready == 1'b0) nrdy++;
            clear_req = (n == 10);
            @(negedge clock);
        end
        clear_req = 1'b0;
        chk("clr_len", 64'(n), 64'(N + 1));
        chk("clr_not_ready", 64'(nrdy), 64'(N + 1));
        chk("clr_hit_map", 64'(hit_map), 64'd0);
        chk("clr_err", 64'(onehot_err), 64'd0);
        chk("clr_total", 64'(total_cnt), 64'd0);
        chk("clr_all_cov", 64'(all_covered), 64'd0);
        rd(6'd0);
        chk("clr_rd0", 64'(rd_data), 64'd0);
        rd(6'd5);
        chk("clr_rd5", 64'(rd_data), 64'd0);
        chk("clr_rd5_valid", 64'(rd_valid), 64'd1);
        rd(6'd39);
        chk("clr_rd39", 64'(rd_data), 64'd0);
        beat(40'h4);
        rd(6'd2);
        chk("post_clr_rd2", 64'(rd_data), 64'd1);

        // Reset in the middle of a sweep.
        clear_req = 1'b1;
        @(negedge clock);
        clear_req = 1'b0;
        repeat (5) @(negedge clock);
        chk("mid_busy", 64'(clear_busy), 64'd1);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(clear_busy), 64'd0);
        chk("mid_rst_total", 64'(total_cnt), 64'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        chk("mid_rel_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rel_rd_ready", 64'(rd_ready), 64'd1);
        beat(40'h10);
        rd(6'd4);
        chk("mid_rel_rd4", 64'(rd_data), 64'd1);
        chk("mid_rel_busy", 64'(clear_busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
